// File: rtl/led_ctrl_frontend.sv
// Button front end for an LED shifter: synchronizes and debounces two push
// buttons, emits one-cycle press strobes and holds the run/speed mode state.
module led_ctrl_frontend #(
    parameter int DB_DIV   = 16,
    parameter int DB_DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_en,
    input  logic btn_speed,
    output logic en,
    output logic speed,
    output logic pulse_en,
    output logic pulse_speed
);

    typedef enum logic [1:0] {
        PAUSE_FAST = 2'b00,
        PAUSE_SLOW = 2'b01,
        RUN_FAST   = 2'b10,
        RUN_SLOW   = 2'b11
    } state_t;

    logic [1:0]          btn_raw;
    logic [1:0]          sync_p0;
    logic [1:0]          sync_p1;
    logic [DB_DIV-1:0]   tick_cnt;
    logic                tick;
    logic [DB_DEPTH-1:0] samp_en_p2;
    logic [DB_DEPTH-1:0] samp_speed_p2;
    logic [1:0]          lvl_p3;
    logic [1:0]          lvl_p4;
    state_t              state;

    assign btn_raw = {btn_speed, btn_en};
    assign tick    = &tick_cnt;

    // Hysteresis: only a full window of agreeing samples moves the level.
    function automatic logic next_level(input logic [DB_DEPTH-1:0] s, input logic cur);
        if (&s)
            return 1'b1;
        else if (~|s)
            return 1'b0;
        else
            return cur;
    endfunction

    function automatic logic is_run(input state_t s);
        return (s == RUN_FAST) || (s == RUN_SLOW);
    endfunction

    function automatic logic is_slow(input state_t s);
        return (s == PAUSE_SLOW) || (s == RUN_SLOW);
    endfunction

    function automatic state_t next_state(input state_t s, input logic t_run, input logic t_spd);
        logic run;
        logic slow;
        run  = is_run(s) ^ t_run;
        slow = is_slow(s) ^ t_spd;
        case ({run, slow})
            2'b00:   return PAUSE_FAST;
            2'b01:   return PAUSE_SLOW;
            2'b10:   return RUN_FAST;
            default: return RUN_SLOW;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0       <= '0;
            sync_p1       <= '0;
            tick_cnt      <= '0;
            samp_en_p2    <= '0;
            samp_speed_p2 <= '0;
            lvl_p3        <= '0;
            lvl_p4        <= '0;
            pulse_en      <= 1'b0;
            pulse_speed   <= 1'b0;
        end else begin
            // p0/p1: two-flop synchronizer
            sync_p0  <= btn_raw;
            sync_p1  <= sync_p0;
            tick_cnt <= tick_cnt + 1'b1;
            // p2: sample window, advanced once per tick
            if (tick) begin
                samp_en_p2    <= {samp_en_p2[DB_DEPTH-2:0], sync_p1[0]};
                samp_speed_p2 <= {samp_speed_p2[DB_DEPTH-2:0], sync_p1[1]};
            end
            // p3/p4: debounced level and its previous value for edge detect
            lvl_p3[0] <= next_level(samp_en_p2, lvl_p3[0]);
            lvl_p3[1] <= next_level(samp_speed_p2, lvl_p3[1]);
            lvl_p4    <= lvl_p3;
            pulse_en    <= lvl_p3[0] & ~lvl_p4[0];
            pulse_speed <= lvl_p3[1] & ~lvl_p4[1];
        end
    end

    // Outputs decode the next state so they move on the same edge as the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= PAUSE_FAST;
            en    <= 1'b0;
            speed <= 1'b0;
        end else begin
            state <= next_state(state, pulse_en, pulse_speed);
            en    <= is_run(next_state(state, pulse_en, pulse_speed));
            speed <= is_slow(next_state(state, pulse_en, pulse_speed));
        end
    end

endmodule

// File: tb/tb_led_ctrl_frontend.sv
// Bench for led_ctrl_frontend: directed button scenarios plus random presses,
// every cycle compared against a behavioural model of the button front end.
module tb_led_ctrl_frontend;

    localparam int DB_DIV   = 2;
    localparam int DB_DEPTH = 4;
    localparam int TP       = 1 << DB_DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_en = 1'b0;
    logic btn_speed = 1'b0;
    logic en, speed, pulse_en, pulse_speed;

    led_ctrl_frontend #(.DB_DIV(DB_DIV), .DB_DEPTH(DB_DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .btn_en(btn_en),
        .btn_speed(btn_speed),
        .en(en),
        .speed(speed),
        .pulse_en(pulse_en),
        .pulse_speed(pulse_speed)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit checking = 0;
    int n_pe, n_ps, n_both, first_pe;

    // Behavioural model: button value history, tick phase, window of ticks.
    int m_cnt;
    bit m_s0[2], m_s1[2], m_lvl[2], m_prev[2], m_pls[2];
    bit m_hist[2][DB_DEPTH];
    bit m_en, m_spd;

    task automatic model_reset();
        m_cnt = 0;
        for (int b = 0; b < 2; b++) begin
            m_s0[b] = 0; m_s1[b] = 0; m_lvl[b] = 0; m_prev[b] = 0; m_pls[b] = 0;
            for (int i = 0; i < DB_DEPTH; i++) m_hist[b][i] = 0;
        end
        m_en = 0;
        m_spd = 0;
    endtask

    task automatic model_step();
        bit tick;
        bit o_pls[2];
        int ones;
        bit o_s1, o_lvl, o_prev;
        tick = (m_cnt % TP) == TP - 1;
        m_cnt++;
        for (int b = 0; b < 2; b++) begin
            o_s1 = m_s1[b]; o_lvl = m_lvl[b]; o_prev = m_prev[b]; o_pls[b] = m_pls[b];
            ones = 0;
            for (int i = 0; i < DB_DEPTH; i++) ones += int'(m_hist[b][i]);
            m_s1[b] = m_s0[b];
            m_s0[b] = (b == 0) ? btn_en : btn_speed;
            if (ones == DB_DEPTH) m_lvl[b] = 1;
            else if (ones == 0) m_lvl[b] = 0;
            if (tick) begin
                for (int i = DB_DEPTH - 1; i > 0; i--) m_hist[b][i] = m_hist[b][i-1];
                m_hist[b][0] = o_s1;
            end
            m_pls[b]  = o_lvl & ~o_prev;
            m_prev[b] = o_lvl;
        end
        if (o_pls[0]) m_en = !m_en;
        if (o_pls[1]) m_spd = !m_spd;
    endtask

    always @(posedge clk) begin
        if (!rst) model_reset();
        else model_step();
    end

    always @(negedge rst) model_reset();

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            cyc++;
            check("en", en, m_en);
            check("speed", speed, m_spd);
            check("pulse_en", pulse_en, m_pls[0]);
            check("pulse_speed", pulse_speed, m_pls[1]);
            if (pulse_en === 1'b1) n_pe++;
            if (pulse_speed === 1'b1) n_ps++;
            if (pulse_en === 1'b1 && pulse_speed === 1'b1) n_both++;
            if (pulse_en === 1'b1 && first_pe < 0) first_pe = cyc;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clear_counts();
        n_pe = 0; n_ps = 0; n_both = 0; first_pe = -1;
    endtask

    task automatic async_reset(input string tag, input int hold);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check({tag, "_en"}, en, 1'b0);
        check({tag, "_speed"}, speed, 1'b0);
        check({tag, "_pulse_en"}, pulse_en, 1'b0);
        check({tag, "_pulse_speed"}, pulse_speed, 1'b0);
        cycles(hold);
        rst = 1'b1;
    endtask

    initial begin
        int t0;
        int k;
        clear_counts();
        model_reset();
        #3;
        rst = 1'b0;
        #1;
        check("init_rst_en", en, 1'b0);
        check("init_rst_speed", speed, 1'b0);
        check("init_rst_pulse_en", pulse_en, 1'b0);
        check("init_rst_pulse_speed", pulse_speed, 1'b0);
        cycles(2);
        rst = 1'b1;
        checking = 1;
        cycles(5);

        // Clean press, twice
        clear_counts();
        btn_en = 1'b1; t0 = cyc;
        cycles(40);
        btn_en = 1'b0;
        cycles(40);
        check_int("clean_pulse_count", n_pe, 1);
        check_int("clean_latency_in_range", int'((first_pe - t0) >= 17 && (first_pe - t0) <= 20), 1);
        check("clean_en_on", en, 1'b1);
        check_int("clean_no_speed_pulse", n_ps, 0);
        btn_en = 1'b1;
        cycles(40);
        btn_en = 1'b0;
        cycles(40);
        check_int("clean2_pulse_count", n_pe, 2);
        check("clean2_en_off", en, 1'b0);

        // Bounce: toggle every cycle, phased so each tick samples a low level
        clear_counts();
        for (int i = 0; i < 30; i++) begin
            btn_speed = (m_cnt % 2) == 0;
            cycles(1);
        end
        btn_speed = 1'b0;
        cycles(40);
        check_int("bounce_no_pulse", n_ps, 0);
        check("bounce_speed_low", speed, 1'b0);

        // Simultaneous press
        clear_counts();
        btn_en = 1'b1; btn_speed = 1'b1;
        cycles(40);
        btn_en = 1'b0; btn_speed = 1'b0;
        cycles(40);
        check_int("both_same_cycle", n_both, 1);
        check_int("both_pe_count", n_pe, 1);
        check("both_en", en, 1'b1);
        check("both_speed", speed, 1'b1);

        // Reset at an arbitrary point, then reset in the middle of a held press
        async_reset("midrst", 2);
        cycles(2);
        btn_en = 1'b1;
        k = 0;
        while (en !== 1'b1 && k < 100) begin
            cycles(1);
            k++;
        end
        check_int("press_en_rise_in_time", int'(k < 100), 1);
        async_reset("heldrst", 3);
        clear_counts();
        t0 = cyc;
        cycles(40);
        btn_en = 1'b0;
        cycles(40);
        check_int("heldrst_pulse_count", n_pe, 1);
        check_int("heldrst_latency", first_pe - t0, 18);
        check("heldrst_en_on", en, 1'b1);

        // Long hold across many counter wraps
        clear_counts();
        btn_en = 1'b1;
        cycles(1000);
        btn_en = 1'b0;
        cycles(40);
        check_int("long_pulse_count", n_pe, 1);
        check_int("long_no_speed_pulse", n_ps, 0);
        check("long_en_off", en, 1'b0);

        // Random segments: bouncing, holding, and occasional resets
        for (int s = 0; s < 40; s++) begin
            int mode;
            int len;
            mode = $urandom_range(0, 5);
            if (mode <= 1) begin
                len = $urandom_range(1, 12);
                for (int i = 0; i < len; i++) begin
                    btn_en    = ($urandom_range(0, 1) == 1);
                    btn_speed = ($urandom_range(0, 1) == 1);
                    cycles(1);
                end
            end else if (mode == 5) begin
                async_reset("rand_rst", $urandom_range(1, 3));
            end else begin
                btn_en    = ($urandom_range(0, 1) == 1);
                btn_speed = ($urandom_range(0, 1) == 1);
                cycles($urandom_range(1, 60));
            end
        end
        btn_en = 1'b0;
        btn_speed = 1'b0;
        cycles(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
